// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit peripheral: FSM states,
// register map and the reset value of the clocks-per-bit divisor.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam logic [3:0] ADDR_TX_DATA  = 4'b0000;
    localparam logic [3:0] ADDR_BAUD_DIV = 4'b0001;
    localparam logic [3:0] ADDR_STATUS   = 4'b0010;
    localparam logic [3:0] ADDR_IRQ_EN   = 4'b0011;

    // 10 MHz system clock / 115200 baud
    localparam logic [15:0] BAUD_DIV_RESET = 16'd87;

    // A divisor of zero behaves like one: every bit lasts at least one clock.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO feeding the transmitter. Circular read/write pointers wrap
// modulo DEPTH; a separate count (one bit wider) gives full/empty.
// A push and a pop on the same edge both take effect, even when full.
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset discards all contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage array needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter on the shared peripheral data bus.
// Writes to TX_DATA queue bytes in a small FIFO; the serialiser drains it
// back-to-back with no idle gap between frames. A level interrupt is
// raised when enabled and the transmitter has fully drained.
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int         DATA_WIDTH    = 32,
    parameter int         FIFO_DEPTH    = 4,
    parameter logic [3:0] TX_DATA_ADDR  = ADDR_TX_DATA,
    parameter logic [3:0] BAUD_DIV_ADDR = ADDR_BAUD_DIV,
    parameter logic [3:0] STATUS_ADDR   = ADDR_STATUS,
    parameter logic [3:0] IRQ_EN_ADDR   = ADDR_IRQ_EN
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire [DATA_WIDTH-1:0]  data,
    input  logic [3:0]            address,
    input  logic                  rw,
    input  logic                  ce,
    output logic                  tx,
    output logic                  irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Bus handshake: a transfer happens on every clk edge where ce=1.
    // rw=1 writes data into the addressed register on that edge; rw=0
    // drives the addressed register onto data for the whole ce cycle.
    logic wr_en;
    logic rd_en;
    logic tx_data_wr;
    logic status_rd;

    assign wr_en      = ce && rw;
    assign rd_en      = ce && !rw;
    assign tx_data_wr = wr_en && (address == TX_DATA_ADDR);
    assign status_rd  = rd_en && (address == STATUS_ADDR);

    logic [15:0]     baud_div;
    logic            irq_en;
    logic            overflow;

    uart_state_e     state;
    logic [15:0]     baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [7:0]      fifo_dout;
    logic [CW-1:0]   fifo_count;

    logic            bit_end;
    logic            busy;
    logic [15:0]     reload;
    logic [6:0]      status;
    logic [DATA_WIDTH-1:0] rdata;

    assign bit_end = (baud_cnt == 16'd0);
    assign busy    = (state != IDLE);
    // Divisor sampled only here, at a bit boundary, so a write never
    // shortens or stretches the bit already on the line.
    assign reload  = eff_div(baud_div) - 16'd1;
    assign status  = {overflow, 3'(fifo_count), fifo_empty, fifo_full, busy};

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_data_wr),
        .pop   (fifo_pop),
        .din   (data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Pop a byte when starting from idle or when a stop bit completes.
    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            IDLE:    fifo_pop = !fifo_empty;
            STOP:    fifo_pop = bit_end && !fifo_empty;
            default: fifo_pop = 1'b0;
        endcase
    end

    // Serialiser FSM: state, baud counter, bit index, shifter and tx line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        shift    <= fifo_dout;
                        state    <= START;
                        tx       <= 1'b0;
                        baud_cnt <= reload;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        tx       <= shift[0];
                        bit_idx  <= 3'd0;
                        baud_cnt <= reload;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= reload;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (!fifo_empty) begin
                            shift    <= fifo_dout;
                            state    <= START;
                            tx       <= 1'b0;
                            baud_cnt <= reload;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    // Control registers, sticky overflow, and the registered interrupt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_div <= BAUD_DIV_RESET;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_en && (address == BAUD_DIV_ADDR)) baud_div <= data[15:0];
            if (wr_en && (address == IRQ_EN_ADDR))   irq_en   <= data[0];
            if (tx_data_wr && fifo_full && !fifo_pop) overflow <= 1'b1;
            else if (status_rd)                       overflow <= 1'b0;
            irq <= irq_en && fifo_empty && !busy;
        end
    end

    // Read mux: addressed register zero-extended, unmapped addresses read 0.
    always_comb begin
        rdata = '0;
        if (address == BAUD_DIV_ADDR)    rdata[15:0] = baud_div;
        else if (address == STATUS_ADDR) rdata[6:0]  = status;
        else if (address == IRQ_EN_ADDR) rdata[0]    = irq_en;
    end

    assign data = rd_en ? rdata : 'z;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: bus driver tasks, a frame-level line model
// with a per-cycle compare process, and directed scenarios with
// hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_tx_periph;
    import uart_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   address = 4'd0;
    logic         rw = 1'b0;
    logic         ce = 1'b0;
    wire [W-1:0]  data;
    logic         tx;
    logic         irq;

    logic         drv_en = 1'b0;
    logic [W-1:0] drv_val = '0;

    assign data = drv_en ? drv_val : 'z;

    always #5 clk = ~clk;

    uart_tx_periph #(
        .DATA_WIDTH (W),
        .FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data    (data),
        .address (address),
        .rw      (rw),
        .ce      (ce),
        .tx      (tx),
        .irq     (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- line model ----------------
    // exp_q holds the expected tx level for each upcoming negedge sample.
    logic [0:0] exp_q[$];
    logic [7:0] byte_q[$];
    logic [7:0] pend_q[$];
    int         m_div = 87;
    bit         chk_en = 1'b0;
    logic       m_exp;

    // An 8N1 frame: start 0, bits LSB first, stop 1, each max(div,1) clocks.
    task automatic model_frame(input logic [7:0] b);
        int d;
        logic [9:0] lvl;
        d   = (m_div == 0) ? 1 : m_div;
        lvl = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++)
            for (int c = 0; c < d; c++)
                exp_q.push_back(lvl[k]);
    endtask

    // Compare tx every cycle, then absorb new bytes and start the next frame.
    always @(negedge clk) begin
        if (chk_en) begin
            m_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
            check("tx_line", {31'b0, tx}, {31'b0, m_exp});
            while (pend_q.size() > 0) begin
                if (byte_q.size() < 4) byte_q.push_back(pend_q.pop_front());
                else void'(pend_q.pop_front());
            end
            if (exp_q.size() == 0 && byte_q.size() > 0)
                model_frame(byte_q.pop_front());
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic bus_write(input logic [3:0] a, input logic [W-1:0] v);
        ce = 1'b1; rw = 1'b1; address = a; drv_en = 1'b1; drv_val = v;
        @(posedge clk);
        if (a == ADDR_TX_DATA)  pend_q.push_back(v[7:0]);
        if (a == ADDR_BAUD_DIV) m_div = int'(v[15:0]);
        @(negedge clk);
        ce = 1'b0; rw = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [W-1:0] v);
        ce = 1'b1; rw = 1'b0; address = a; drv_en = 1'b0;
        #1 v = data;
        @(posedge clk);
        @(negedge clk);
        ce = 1'b0;
    endtask

    // Hold a continuous STATUS read and watch the busy bit for n samples.
    task automatic watch_busy(input int n, output int busy_cycles, output int falls);
        logic prev;
        busy_cycles = 0; falls = 0; prev = 1'b0;
        ce = 1'b1; rw = 1'b0; address = ADDR_STATUS; drv_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (data[0]) busy_cycles++;
            else if (prev) falls++;
            prev = data[0];
        end
        ce = 1'b0;
        @(negedge clk);
    endtask

    logic a5_lvl [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    // ---------------- directed scenarios ----------------
    initial begin
        logic [W-1:0] r;
        int bc, fl, n_busy, idle_run;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'b0, tx}, 1);
        check("rst_irq", {31'b0, irq}, 0);
        rst = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        bus_read(ADDR_STATUS, r);   check("rst_status", r, 32'h04);
        bus_read(ADDR_BAUD_DIV, r); check("rst_baud", r, 32'd87);
        bus_read(ADDR_IRQ_EN, r);   check("rst_irq_en", r, 0);
        bus_read(4'hF, r);          check("unmapped_read", r, 0);
        bus_read(ADDR_TX_DATA, r);  check("tx_data_read", r, 0);

        // Bus released when not reading: bench's own drive must survive
        ce = 1'b0; rw = 1'b0; address = ADDR_BAUD_DIV;
        drv_en = 1'b1; drv_val = 32'hA5A5_0000;
        #1 check("bus_release", data, 32'hA5A5_0000);
        drv_en = 1'b0;
        @(negedge clk);

        // 0xA5 at 4 clocks per bit
        bus_write(ADDR_BAUD_DIV, 32'd4);
        bus_read(ADDR_BAUD_DIV, r); check("baud_rb", r, 32'd4);
        bus_write(ADDR_TX_DATA, 32'hA5);
        ce = 1'b1; rw = 1'b0; address = ADDR_STATUS;
        #1 check("a5_not_busy_yet", {31'b0, data[0]}, 0);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1 check("a5_level", {31'b0, tx}, {31'b0, a5_lvl[i / 4]});
            if (data[0]) bc++;
        end
        @(negedge clk);
        #1 check("a5_busy_fell", {31'b0, data[0]}, 0);
        check("a5_busy_cycles", bc, 40);
        ce = 1'b0;
        @(negedge clk);

        // Divisor 0 -> one clock per bit, 10-clock frame
        bus_write(ADDR_BAUD_DIV, 32'd0);
        bus_read(ADDR_BAUD_DIV, r); check("baud0_rb", r, 0);
        bus_write(ADDR_TX_DATA, 32'h3C);
        watch_busy(14, bc, fl);
        check("div0_busy_cycles", bc, 10);
        check("div0_busy_falls", fl, 1);

        // Two bytes back-to-back at divisor 2: one continuous 40-clock busy run
        bus_write(ADDR_BAUD_DIV, 32'd2);
        bus_write(ADDR_TX_DATA, 32'h01);
        bus_write(ADDR_TX_DATA, 32'h02);
        watch_busy(45, bc, fl);
        check("b2b_busy_cycles", bc, 40);
        check("b2b_no_gap", fl, 1);

        // Overflow: kick one byte, then five writes while the line is busy.
        // Expected STATUS = overflow|count 4|full|busy = 0x40|0x20|0x02|0x01.
        bus_write(ADDR_TX_DATA, 32'h11);
        @(negedge clk);
        bus_write(ADDR_TX_DATA, 32'h21);
        bus_write(ADDR_TX_DATA, 32'h22);
        bus_write(ADDR_TX_DATA, 32'h23);
        bus_write(ADDR_TX_DATA, 32'h24);
        bus_write(ADDR_TX_DATA, 32'h25);
        bus_read(ADDR_STATUS, r); check("ovf_status", r, 32'h63);
        bus_read(ADDR_STATUS, r); check("ovf_cleared", r, 32'h23);
        repeat (110) @(negedge clk);
        bus_read(ADDR_STATUS, r); check("drained_status", r, 32'h04);

        // Interrupt behaviour
        bus_write(ADDR_IRQ_EN, 32'd1);
        @(negedge clk);
        check("irq_idle_enabled", {31'b0, irq}, 1);
        bus_read(ADDR_IRQ_EN, r); check("irq_en_rb", r, 1);
        bus_write(ADDR_TX_DATA, 32'h5A);
        ce = 1'b1; rw = 1'b0; address = ADDR_STATUS;
        n_busy = 0; idle_run = 0;
        for (int i = 0; i < 30; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (data[0]) begin
                n_busy++;
                check("irq_low_while_busy", {31'b0, irq}, 0);
            end else if (n_busy > 0) begin
                idle_run++;
                if (idle_run == 2) check("irq_after_idle", {31'b0, irq}, 1);
            end
        end
        ce = 1'b0;
        check("irq_frame_busy", n_busy, 20);
        check("irq_idle_reached", (idle_run >= 2) ? 1 : 0, 1);
        @(negedge clk);
        bus_write(ADDR_IRQ_EN, 32'd0);
        @(negedge clk);
        check("irq_disabled", {31'b0, irq}, 0);

        // Reset during DATA bit 3 of a 0x00 frame, with a second byte queued
        bus_write(ADDR_BAUD_DIV, 32'd4);
        bus_write(ADDR_TX_DATA, 32'h00);
        bus_write(ADDR_TX_DATA, 32'h00);
        repeat (17) @(negedge clk);
        check("bit3_low", {31'b0, tx}, 0);
        #2 rst = 1'b0;
        chk_en = 1'b0;
        #1 check("rst_async_tx", {31'b0, tx}, 1);
        check("rst_async_irq", {31'b0, irq}, 0);
        exp_q.delete(); byte_q.delete(); pend_q.delete();
        m_div = 87;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;
        bus_read(ADDR_STATUS, r);   check("post_rst_status", r, 32'h04);
        bus_read(ADDR_BAUD_DIV, r); check("post_rst_baud", r, 32'd87);
        repeat (60) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
